cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Parametrised CPU clock controller: it generates the slow board-level CPU clock from the board clock and replaces the fixed two-rate divider. It adds a selectable divide ratio, run/halt control and single-step from a button, along with a per-cycle enable pulse and a CPU cycle counter for the display logic. The block sits between the board clock, switches and buttons and the CPU core's clock input.

## Interface
- CNT_W, 32: half-period counter width.
- SEL_W, 1: rate-select width, giving 2^SEL_W rates.
- TAP_BASE, 26: log2 of the half-period at SEL=0.
- TAP_STEP, 3: log2 increment of the half-period per SEL step.
- CYC_W, 32: CPU cycle counter width.
- DB_W, 20: debounce stability window is 2^DB_W cycles; used only with the debounce macro.
- CLK  in  1  board clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- SEL  in  SEL_W  rate select. Half-period H = 2^(TAP_BASE + SEL*TAP_STEP) CLK cycles.
- RUN  in  1  level: 1 = free-run, 0 = halt.
- STEP  in  1  single-step button level.
- CLK_CPU  out  1  CPU clock, registered, 50% duty.
- CPU_EN  out  1  one-CLK-cycle pulse on each CLK_CPU rise.
- HALTED  out  1  high in S_HALT.
- CYC_CNT  out  CYC_W  count of CLK_CPU rising edges.

## Operation
- Reset values: CLK_CPU=0, CPU_EN=0, HALTED=1, CYC_CNT=0, state S_HALT, hcnt=0, sel_q=0.
- Elaboration check: TAP_BASE + (2^SEL_W-1)*TAP_STEP < CNT_W; a violation is a fatal error.
- hcnt counts CLK cycles within the current half-period. When hcnt = H-1, CLK_CPU toggles and hcnt returns to 0.
- sel_q is sampled from SEL only on a CLK_CPU 1->0 toggle or on leaving S_HALT. A rate change therefore never shortens the current period, so there are no runt pulses.
- CPU_EN is high exactly in the cycle in which the registered CLK_CPU is first 1 after a rise. On the same edge, CYC_CNT increments, wrapping modulo 2^CYC_W.
- FSM states:
  - S_HALT: CLK_CPU is held at 0 and hcnt is held at 0.
    - RUN=1 -> S_RUN.
    - Otherwise a step request -> S_STEP.
    - RUN has priority over a simultaneous step request.
  - S_RUN: CLK_CPU toggles continuously. If RUN=0 is sampled, the current period completes; the state moves to S_HALT on the next 1->0 toggle.
  - S_STEP: exactly one period is produced (H high, then H low), then the state moves to S_HALT. If RUN=1 is seen during the step, the state moves to S_RUN at the end of the period instead.
- Step request: a 0->1 edge of the conditioned STEP. Step requests arriving in S_RUN or S_STEP are discarded, not queued.
- RST asserted mid-period: all state returns to its reset value immediately (asynchronously); no partial period is completed.

## Timing
- Leaving S_HALT, RUN or a step request is sampled at edge k. After edge k+1, CLK_CPU=1 and CPU_EN=1.
- High phase = H CLK cycles and low phase = H CLK cycles, exactly; the period is 2H.
- With TAP_BASE=26, TAP_STEP=3, SEL_W=1, the periods are 2^27 and 2^30 CLK cycles.
- HALTED rises in the same cycle that CLK_CPU falls for the last time. HALTED falls on the edge that leaves S_HALT.

## Configuration
- CPU_CLK_DEBOUNCE_EN defined:
  - STEP passes through a 2-FF synchroniser and then a debouncer.
  - The debounced level changes only after the synchronised input has been stable for 2^DB_W consecutive CLK cycles.
  - Request latency is 2 + 2^DB_W + 1 cycles from a clean press.
- CPU_CLK_DEBOUNCE_EN undefined:
  - STEP is treated as clean and synchronous.
  - It is registered once for edge detection, so the request is seen 1 cycle after STEP rises.
  - DB_W is unused.

## Structure
- Package cpu_clk_pkg holds:
  - the state enum typedef (S_HALT, S_RUN, S_STEP);
  - default parameter constants;
  - a function tap_of(sel) returning TAP_BASE + sel*TAP_STEP.
- One sub-module, step_debounce (synchroniser plus stability counter). It is instantiated only under CPU_CLK_DEBOUNCE_EN.

## Test plan
All scenarios use CNT_W=8, TAP_BASE=2, TAP_STEP=1, SEL_W=1, CYC_W=8, with the macro undefined.
- Reset, then RUN=1, SEL=0:
  - CLK_CPU rises 2 cycles after the first RUN sample, then 4 high / 4 low repeatedly.
  - CPU_EN is 1 cycle wide per rise.
  - CYC_CNT=5 after 5 rises.
- In S_RUN, SEL switched 0->1 mid-high-phase:
  - the current period stays 4/4;
  - subsequent periods are 8/8.
- RUN dropped mid-high-phase:
  - the period completes;
  - HALTED=1 at the falling toggle;
  - CLK_CPU stays 0 for 50 cycles.
- Halted, two STEP pulses 20 cycles apart:
  - exactly two 4/4 periods;
  - CYC_CNT increases by 2.
  - A STEP pulse during a step period adds nothing.
- RST asserted in the middle of a step, while CLK_CPU=1:
  - all outputs return to their reset values immediately.
- With CPU_CLK_DEBOUNCE_EN and DB_W=3:
  - a STEP bounce of 1-cycle glitches yields no step;
  - a clean 20-cycle press yields exactly one step.
- CYC_CNT wraps from 255 to 0 after 256 rises.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared types, default parameters and the half-period tap helper
// for the CPU clock controller.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_e;

    localparam int DEF_CNT_W    = 32;
    localparam int DEF_SEL_W    = 1;
    localparam int DEF_TAP_BASE = 26;
    localparam int DEF_TAP_STEP = 3;
    localparam int DEF_CYC_W    = 32;
    localparam int DEF_DB_W     = 20;

    // log2 of the half-period (in CLK cycles) for a given rate select
    function automatic int tap_of(input int sel,
                                  input int tap_base = DEF_TAP_BASE,
                                  input int tap_step = DEF_TAP_STEP);
        return tap_base + sel * tap_step;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_step_debounce.sv
// step_debounce: 2-FF synchroniser followed by a stability-window debouncer.
// The output level follows the synchronised input only after it has held a
// new value for 2^DB_W consecutive CLK cycles.
module step_debounce #(
    parameter int DB_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // synchroniser shift and stability counter; counter restarts on any bounce
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == {DB_W{1'b1}}) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: divides the board clock down to a 50% duty CPU clock with a
// selectable rate, run/halt control and single-step. CPU_EN pulses for one
// CLK cycle on each CLK_CPU rise and CYC_CNT counts those rises.
// Build option: define CPU_CLK_DEBOUNCE_EN to synchronise and debounce STEP;
// otherwise STEP is taken as a clean, synchronous level.
// DBG_STATE exposes the FSM state.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int TAP_BASE = DEF_TAP_BASE,
    parameter int TAP_STEP = DEF_TAP_STEP,
    parameter int CYC_W    = DEF_CYC_W,
    parameter int DB_W     = DEF_DB_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SEL_W-1:0] SEL,
    input  logic             RUN,
    input  logic             STEP,
    output logic             CLK_CPU,
    output logic             CPU_EN,
    output logic             HALTED,
    output logic [CYC_W-1:0] CYC_CNT,
    output state_e           DBG_STATE
);

    if (TAP_BASE + (2 ** SEL_W - 1) * TAP_STEP >= CNT_W) begin : g_bad_tap
        $fatal(1, "cpu_clk_ctrl: largest half-period tap does not fit in CNT_W");
    end
    if (DB_W < 1) begin : g_bad_db
        $fatal(1, "cpu_clk_ctrl: DB_W must be at least 1");
    end

    // half-period minus one, in CLK cycles, for a rate select value
    function automatic logic [CNT_W-1:0] half_m1(input logic [SEL_W-1:0] s);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (one << tap_of(int'(s), TAP_BASE, TAP_STEP)) - one;
    endfunction

    logic step_lvl;

`ifdef CPU_CLK_DEBOUNCE_EN
    step_debounce #(
        .DB_W(DB_W)
    ) u_step_db (
        .clk (CLK),
        .rst (RST),
        .din (STEP),
        .dout(step_lvl)
    );
`else
    assign step_lvl = STEP;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hm1_q, hm1_d;     // active half-period minus one
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             clk_q, clk_d;
    logic             en_q, en_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             stop_q, stop_d;   // RUN=0 seen while running
    logic             runs_q, runs_d;   // RUN=1 seen during a step
    logic             stp_prev_q, stp_prev_d;
    logic             step_req;
    logic             toggle;

    assign step_req = step_lvl & ~stp_prev_q;
    assign toggle   = (hcnt_q == hm1_q);

    // next-state, half-period counting and output generation
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        hm1_d      = hm1_q;
        sel_d      = sel_q;
        clk_d      = clk_q;
        en_d       = 1'b0;
        cyc_d      = cyc_q;
        stop_d     = stop_q;
        runs_d     = runs_q;
        stp_prev_d = step_lvl;
        case (state_q)
            S_HALT: begin
                hcnt_d = '0;
                clk_d  = 1'b0;
                stop_d = 1'b0;
                runs_d = 1'b0;
                // preload so the first rise comes on the next edge
                if (RUN || step_req) begin
                    state_d = RUN ? S_RUN : S_STEP;
                    sel_d   = SEL;
                    hm1_d   = half_m1(SEL);
                    hcnt_d  = half_m1(SEL);
                end
            end
            S_RUN, S_STEP: begin
                if (state_q == S_RUN && !RUN) stop_d = 1'b1;
                if (state_q == S_STEP && RUN) runs_d = 1'b1;
                if (toggle) begin
                    hcnt_d = '0;
                    clk_d  = ~clk_q;
                    if (!clk_q) begin
                        // rise: new period length takes effect here only
                        en_d  = 1'b1;
                        cyc_d = cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
                        hm1_d = half_m1(sel_q);
                    end else begin
                        // fall: sample rate for the next period, decide halt
                        sel_d  = SEL;
                        stop_d = 1'b0;
                        runs_d = 1'b0;
                        if (state_q == S_RUN) begin
                            state_d = (stop_q || !RUN) ? S_HALT : S_RUN;
                        end else begin
                            state_d = (runs_q || RUN) ? S_RUN : S_HALT;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_HALT;
                clk_d   = 1'b0;
                hcnt_d  = '0;
            end
        endcase
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_HALT;
            hcnt_q     <= '0;
            hm1_q      <= '0;
            sel_q      <= '0;
            clk_q      <= 1'b0;
            en_q       <= 1'b0;
            cyc_q      <= '0;
            stop_q     <= 1'b0;
            runs_q     <= 1'b0;
            stp_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            hm1_q      <= hm1_d;
            sel_q      <= sel_d;
            clk_q      <= clk_d;
            en_q       <= en_d;
            cyc_q      <= cyc_d;
            stop_q     <= stop_d;
            runs_q     <= runs_d;
            stp_prev_q <= stp_prev_d;
        end
    end

    assign CLK_CPU   = clk_q;
    assign CPU_EN    = en_q;
    assign HALTED    = (state_q == S_HALT);
    assign CYC_CNT   = cyc_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: bench for cpu_clk_ctrl with H = 4 (SEL=0) or 8 (SEL=1).
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int CYC_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic run;
  logic step;
  logic clk_cpu;
  logic cpu_en;
  logic halted;
  logic [CYC_W-1:0] cyc_cnt;
  state_e dbg_state;

  cpu_clk_ctrl #(
    .CNT_W(8), .SEL_W(1), .TAP_BASE(2), .TAP_STEP(1), .CYC_W(CYC_W), .DB_W(3)
  ) dut (
    .CLK(clk), .RST(rst), .SEL(sel), .RUN(run), .STEP(step),
    .CLK_CPU(clk_cpu), .CPU_EN(cpu_en), .HALTED(halted),
    .CYC_CNT(cyc_cnt), .DBG_STATE(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [CYC_W-1:0] exp_q[$];
  logic [CYC_W-1:0] cyc_model;
  int hi_q[$];
  int lo_q[$];
  int phase_len;
  logic prev_clk;
  int t;
  int rises;

  typedef struct {
    logic sel;
    int   n;
    int   hi;
    int   lo;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one CLK cycle; sample #1 after the edge, score CPU_EN, record phase lengths
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (rst) begin
      prev_clk = 1'b0;
      phase_len = 0;
      return;
    end
    check("cpu_en_shape", cpu_en, clk_cpu && !prev_clk);
    if (cpu_en) begin
      rises++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rise: got rise with cyc_cnt=%0d expected none", cyc_cnt);
      end else begin
        check("cyc_cnt", cyc_cnt, exp_q.pop_front());
      end
    end
    if (clk_cpu != prev_clk) begin
      if (prev_clk) hi_q.push_back(phase_len);
      else lo_q.push_back(phase_len);
      phase_len = 1;
    end else begin
      phase_len++;
    end
    prev_clk = clk_cpu;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_model = cyc_model + 1'b1;
      exp_q.push_back(cyc_model);
    end
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int k = 0;
    while (rises < target && k < budget) begin
      tick();
      k++;
    end
    check({name, "_rises"}, rises, target);
  endtask

  task automatic wait_low(input int budget);
    int k = 0;
    while (clk_cpu !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic idle_check(input int n, input string name);
    int highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (clk_cpu) highs++;
    end
    check({name, "_idle_highs"}, highs, 0);
    check({name, "_cyc"}, cyc_cnt, cyc_model);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // free-run n periods at a fixed rate, drop RUN mid-high after the last rise
  task automatic run_vec(input logic s, input int n, input int hi, input int lo, input string name);
    int t0;
    hi_q.delete();
    lo_q.delete();
    rises = 0;
    sel = s;
    run = 1'b1;
    t0 = t;
    push_exp(n);
    wait_rises(1, 20, {name, "_first"});
    check({name, "_start_lat"}, t - t0, 2);
    check({name, "_running"}, halted, 0);
    if (n > 1) wait_rises(n, n * (hi + lo) + 20, name);
    run = 1'b0;
    wait_low(hi + 4);
    check({name, "_halted_at_fall"}, halted, 1);
    check({name, "_state"}, dbg_state, S_HALT);
    check({name, "_hi_count"}, hi_q.size(), n);
    check({name, "_lo_count"}, lo_q.size(), n);
    foreach (hi_q[i]) check({name, "_hi_len"}, hi_q[i], hi);
    for (int i = 1; i < lo_q.size(); i++) check({name, "_lo_len"}, lo_q[i], lo);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    run = 1'b0;
    step = 1'b0;
    cyc_model = '0;
    phase_len = 0;
    prev_clk = 1'b0;
    t = 0;
    rises = 0;

    vecs[0] = '{sel: 1'b0, n: 5, hi: 4, lo: 4};
    vecs[1] = '{sel: 1'b1, n: 3, hi: 8, lo: 8};
    vecs[2] = '{sel: 1'b0, n: 2, hi: 4, lo: 4};

    // reset state
    tick();
    tick();
    check("rst_clk_cpu", clk_cpu, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_halted", halted, 1);
    check("rst_cyc", cyc_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_halted", halted, 1);

    // table-driven free-run vectors
    for (int v = 0; v < 3; v++) begin
      run_vec(vecs[v].sel, vecs[v].n, vecs[v].hi, vecs[v].lo, $sformatf("vec%0d", v));
      idle_check(50, $sformatf("vec%0d", v));
    end
    check("cyc_after_vecs", cyc_cnt, 10);

    // rate change mid-high: current period stays 4/4, later ones 8/8
    hi_q.delete();
    lo_q.delete();
    rises = 0;
    sel = 1'b0;
    run = 1'b1;
    push_exp(3);
    wait_rises(1, 20, "selsw_first");
    tick();
    tick();
    sel = 1'b1;
    wait_rises(3, 100, "selsw");
    run = 1'b0;
    wait_low(12);
    check("selsw_hi_count", hi_q.size(), 3);
    check("selsw_lo_count", lo_q.size(), 3);
    if (hi_q.size() == 3 && lo_q.size() == 3) begin
      check("selsw_hi0", hi_q[0], 4);
      check("selsw_lo1", lo_q[1], 4);
      check("selsw_hi1", hi_q[1], 8);
      check("selsw_lo2", lo_q[2], 8);
      check("selsw_hi2", hi_q[2], 8);
    end
    check("selsw_halted", halted, 1);
    idle_check(30, "selsw");

    // two single steps 20 cycles apart; an extra press during a step is dropped
    sel = 1'b0;
    rises = 0;
    hi_q.delete();
    for (int s = 0; s < 2; s++) begin
      int t0;
      t0 = t;
      step = 1'b1;
      push_exp(1);
      tick();
      step = 1'b0;
      tick();
      check("step_lat", t - t0, 2);
      check("step_rises", rises, s + 1);
      tick();
      check("step_not_halted", halted, 0);
      check("step_state", dbg_state, S_STEP);
      step = 1'b1;
      tick();
      step = 1'b0;
      while (t - t0 < 20) tick();
      check("step_halted", halted, 1);
    end
    check("step_hi_count", hi_q.size(), 2);
    foreach (hi_q[i]) check("step_hi_len", hi_q[i], 4);
    idle_check(30, "step");
    check("step_total_rises", rises, 2);

    // asynchronous reset while CLK_CPU is high in a step
    step = 1'b1;
    push_exp(1);
    tick();
    step = 1'b0;
    tick();
    tick();
    check("mid_step_clk_high", clk_cpu, 1);
    rst = 1'b1;
    #1;
    check("async_rst_clk", clk_cpu, 0);
    check("async_rst_en", cpu_en, 0);
    check("async_rst_halted", halted, 1);
    check("async_rst_cyc", cyc_cnt, 0);
    cyc_model = '0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    idle_check(20, "after_rst");

    // counter wrap: 256 rises bring CYC_CNT back to 0
    run_vec(1'b0, 256, 4, 4, "wrap");
    check("wrap_zero", cyc_cnt, 0);
    idle_check(10, "wrap");

`ifdef CPU_CLK_DEBOUNCE_EN
    // bouncing input gives nothing, a clean press gives one step
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    for (int i = 0; i < 30; i++) tick();
    check("db_glitch_rises", rises, 0);
    push_exp(1);
    step = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    step = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("db_press_rises", rises, 1);
    check("db_sb_empty", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
